// File: rtl/ysyx_22050612_dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, byte-masked stores into a
// 64-bit word array, full aligned doubleword returned a fixed LATENCY cycles after acceptance.
module ysyx_22050612_dmem_responder #(
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [63:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    wen_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [63:0]             wdata_q;
  logic [7:0]              wmask_q;
  logic                    inrange_q;

  logic [63:0]             mem [DEPTH];

  logic [60:0]             wofs;
  logic                    in_range;
  logic                    accept;
  logic                    exec;

  // Word offset from BASE; once addr >= BASE is known, the offset is in range iff its
  // bits above the index are zero, which avoids any 64-bit wrap of BASE + size.
  assign wofs     = req_addr[63:3] - BASE[63:3];
  assign in_range = (req_addr >= BASE) && ((wofs >> DEPTH_LOG2) == 61'd0);
  assign accept   = (state_q == IDLE) && req_valid;
  assign exec     = (state_q == WAIT) && (cnt_q == 4'd0);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (!inrange_q) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (wen_q) begin
            rdata_d = '0;
          end else begin
            rdata_d = mem[idx_q];
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are captured once at acceptance; the initiator may change them afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q     <= req_wen;
      idx_q     <= wofs[DEPTH_LOG2-1:0];
      wdata_q   <= req_wdata;
      wmask_q   <= req_wmask;
      inrange_q <= in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (exec && wen_q && inrange_q) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
// Directed bench for ysyx_22050612_dmem_responder; instance 0 uses LATENCY=2,
// instances 1 and 2 use LATENCY=1 and LATENCY=15 for the back-to-back runs.
module tb_ysyx_22050612_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [3];
  logic        req_wen    [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic [7:0]  req_wmask  [3];
  logic        resp_ready [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050612_dmem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  ysyx_22050612_dmem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  ysyx_22050612_dmem_responder #(.LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wmask(req_wmask[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  // Full request/response transaction; lat = cycles from acceptance edge to resp_valid, -1 on timeout.
  task automatic do_req(input int k, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask,
                        output logic [63:0] rd, output logic er, output int lat);
    int n;
    req_wen[k] = wen; req_addr[k] = addr; req_wdata[k] = wdata; req_wmask[k] = mask;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_addr[k] = '1; req_wdata[k] = 64'h5A5A_5A5A_5A5A_5A5A; req_wmask[k] = '1;
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata[k]; er = resp_err[k];
    if (!resp_valid[k]) lat = -1;
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({req_ready[k], resp_valid[k], resp_err[k], resp_rdata[k]} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
        errors++;
        $display("FAIL reset_outputs inst %0d: got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
                 k, req_ready[k], resp_valid[k], resp_err[k], resp_rdata[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er; int lat;
    do_req(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h0, 1'b0} || lat !== 2) begin
      errors++; $display("FAIL store_full: got rdata=%h err=%b lat=%0d want 0 0 2", rd, er, lat);
    end
    do_req(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h1122_3344_5566_7788, 1'b0} || lat !== 2) begin
      errors++; $display("FAIL load_full: got rdata=%h err=%b lat=%0d want 1122334455667788 0 2", rd, er, lat);
    end
  endtask

  task automatic test_masked();
    logic [63:0] rd; logic er; int lat;
    do_req(0, 1'b1, 64'h8000_0010, 64'hAB00_0000_0000_0000, 8'h80, rd, er, lat);
    do_req(0, 1'b1, 64'h8000_0013, 64'h0000_0000_CD00_0000, 8'h08, rd, er, lat);
    do_req(0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h0, 1'b0}) begin
      errors++; $display("FAIL store_mask0: got rdata=%h err=%b want 0 0", rd, er);
    end
    do_req(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'hAB22_3344_CD66_7788, 1'b0}) begin
      errors++; $display("FAIL load_masked: got rdata=%h err=%b want ab223344cd667788 0", rd, er);
    end
  endtask

  task automatic test_range();
    logic [63:0] rd; logic er; int lat;
    do_req(0, 1'b1, 64'h8000_0000, 64'h0BAD_F00D_0000_0001, 8'hFF, rd, er, lat);
    do_req(0, 1'b1, 64'h8000_7FF8, 64'h7FF8_7FF8_7FF8_7FF8, 8'hFF, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL store_last_word: got err=%b want 0", er);
    end
    do_req(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h0, 1'b1} || lat !== 2) begin
      errors++; $display("FAIL load_below_base: got rdata=%h err=%b lat=%0d want 0 1 2", rd, er, lat);
    end
    do_req(0, 1'b0, 64'h8000_8000, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h0, 1'b1}) begin
      errors++; $display("FAIL load_above_top: got rdata=%h err=%b want 0 1", rd, er);
    end
    do_req(0, 1'b1, 64'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h0, 1'b1}) begin
      errors++; $display("FAIL store_addr0: got rdata=%h err=%b want 0 1", rd, er);
    end
    do_req(0, 1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
    do_req(0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h0BAD_F00D_0000_0001, 1'b0}) begin
      errors++; $display("FAIL word0_untouched: got rdata=%h err=%b want 0badf00d00000001 0", rd, er);
    end
    do_req(0, 1'b0, 64'h8000_7FF8, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h7FF8_7FF8_7FF8_7FF8, 1'b0}) begin
      errors++; $display("FAIL last_word_untouched: got rdata=%h err=%b want 7ff87ff87ff87ff8 0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat;
    int n;
    req_wen[0] = 1'b0; req_addr[0] = 64'h8000_0010; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({resp_valid[0], resp_err[0], req_ready[0], resp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 64'hAB22_3344_CD66_7788}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got vld=%b err=%b rdy=%b rdata=%h want 1 0 0 ab223344cd667788",
                 c, resp_valid[0], resp_err[0], req_ready[0], resp_rdata[0]);
      end
      if (c == 2) begin
        req_wen[0] = 1'b1; req_wdata[0] = 64'h0; req_wmask[0] = 8'hFF; req_valid[0] = 1'b1;
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    checks++;
    if ({req_ready[0], resp_valid[0]} !== 2'b10) begin
      errors++; $display("FAIL release_idle: got rdy=%b vld=%b want 1 0", req_ready[0], resp_valid[0]);
    end
    do_req(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if (rd !== 64'hAB22_3344_CD66_7788) begin
      errors++; $display("FAIL ignored_pulse: got rdata=%h want ab223344cd667788", rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] rd; logic er; int lat;
    logic seen_valid;
    do_req(0, 1'b1, 64'h8000_0020, 64'h5555_5555_5555_5555, 8'hFF, rd, er, lat);
    do_req(0, 1'b0, 64'h8000_0020, 64'h0, 8'h00, rd, er, lat);
    req_wen[0] = 1'b1; req_addr[0] = 64'h8000_0020; req_wdata[0] = '1; req_wmask[0] = 8'hFF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({req_ready[0], resp_valid[0], resp_err[0], resp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL abort_reset_outputs: got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
               req_ready[0], resp_valid[0], resp_err[0], resp_rdata[0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      seen_valid |= resp_valid[0];
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_resp: got resp_valid seen=%b want 0", seen_valid);
    end
    do_req(0, 1'b0, 64'h8000_0020, 64'h0, 8'h00, rd, er, lat);
    checks++;
    if ({rd, er} !== {64'h5555_5555_5555_5555, 1'b0} || lat !== 2) begin
      errors++; $display("FAIL abort_not_written: got rdata=%h err=%b lat=%0d want 5555555555555555 0 2", rd, er, lat);
    end
  endtask

  function automatic logic [63:0] b2b_data(input int k, input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(k) << 16) | 64'(i + 1);
  endfunction

  task automatic b2b_drive(input int k, input int j);
    int a;
    a = (j < 4) ? j : 7 - j;
    req_wen[k]   = (j < 4);
    req_addr[k]  = 64'h8000_0100 + 64'(8 * a);
    req_wdata[k] = b2b_data(k, a);
    req_wmask[k] = 8'hFF;
  endtask

  task automatic test_back_to_back(input int k, input int lat);
    int          acc_cyc [8];
    logic [63:0] rd      [8];
    logic        er      [8];
    int          nacc, nresp;
    logic        acc_now, hs_now, extra;
    nacc = 0; nresp = 0;
    b2b_drive(k, 0);
    req_valid[k] = 1'b1; resp_ready[k] = 1'b1;
    for (int c = 0; c < 400 && nresp < 8; c++) begin
      acc_now = req_valid[k] && req_ready[k];
      hs_now  = resp_valid[k] && resp_ready[k];
      if (hs_now) begin rd[nresp] = resp_rdata[k]; er[nresp] = resp_err[k]; nresp++; end
      @(posedge clk); #1;
      if (acc_now) begin
        acc_cyc[nacc] = c; nacc++;
        if (nacc < 8) b2b_drive(k, nacc); else req_valid[k] = 1'b0;
      end
    end
    extra = 1'b0;
    for (int c = 0; c < lat + 3; c++) begin
      extra |= resp_valid[k];
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0; resp_ready[k] = 1'b0;
    checks++;
    if (nacc !== 8 || nresp !== 8 || extra !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count_L%0d: got acc=%0d resp=%0d extra=%b want 8 8 0", lat, nacc, nresp, extra);
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== lat + 2) begin
          errors++;
          $display("FAIL b2b_period_L%0d_%0d: got %0d want %0d", lat, i, acc_cyc[i] - acc_cyc[i-1], lat + 2);
        end
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({rd[i], er[i]} !== {((i < 4) ? 64'h0 : b2b_data(k, 7 - i)), 1'b0}) begin
          errors++;
          $display("FAIL b2b_resp_L%0d_%0d: got rdata=%h err=%b want %h 0", lat, i, rd[i], er[i],
                   (i < 4) ? 64'h0 : b2b_data(k, 7 - i));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_wmask[k] = '0; resp_ready[k] = 1'b0;
    end
    test_reset();
    test_store_load();
    test_masked();
    test_range();
    test_backpressure();
    test_reset_abort();
    test_back_to_back(1, 1);
    test_back_to_back(2, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
